// File: rtl/leg_recover_pkg.sv
// Shared FSM state encoding and default operand width for leg_recover.
package leg_recover_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    ROOT   = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root step: keep the trial bit if (y | bit)^2 still fits under d.
module isqrt_step
  import leg_recover_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]   y,
  input  logic [WIDTH-1:0]   bit_in,
  input  logic [2*WIDTH-1:0] d,
  output logic [WIDTH-1:0]   y_next
);

  logic [WIDTH-1:0]   trial;
  logic [2*WIDTH-1:0] trial_ext;
  logic [2*WIDTH-1:0] trial_sq;

  assign trial     = y | bit_in;
  assign trial_ext = {{WIDTH{1'b0}}, trial};
  assign trial_sq  = trial_ext * trial_ext;
  assign y_next    = (trial_sq <= d) ? trial : y;

endmodule

// File: rtl/leg_recover.sv
// Recovers leg y = isqrt(r^2 - x^2) one bit per cycle; define LEG_RECOVER_ROUND_EN to round to nearest.
module leg_recover
  import leg_recover_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] x_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y_out,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int DW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, x_q, x_d;
  logic [WIDTH-1:0] acc_q, acc_d, bit_q, bit_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [DW-1:0]    d_q, d_d;
  logic             err_q, err_d, out_valid_q, out_valid_d, in_ready_q, in_ready_d;

  logic [DW-1:0]    r_sq, x_sq;
  logic [WIDTH-1:0] step_y, final_y;

  assign r_sq = {{WIDTH{1'b0}}, r_q} * {{WIDTH{1'b0}}, r_q};
  assign x_sq = {{WIDTH{1'b0}}, x_q} * {{WIDTH{1'b0}}, x_q};

  isqrt_step #(.WIDTH(WIDTH)) u_step (
    .y      (acc_q),
    .bit_in (bit_q),
    .d      (d_q),
    .y_next (step_y)
  );

`ifdef LEG_RECOVER_ROUND_EN
  logic [DW-1:0] step_sq, rem;
  assign step_sq = {{WIDTH{1'b0}}, step_y} * {{WIDTH{1'b0}}, step_y};
  assign rem     = d_q - step_sq;
  // Remainder above y means d sits past (y + 0.5)^2, so round up unless already saturated.
  assign final_y = (rem > {{WIDTH{1'b0}}, step_y} && step_y != {WIDTH{1'b1}}) ?
                   step_y + 1'b1 : step_y;
`else
  assign final_y = step_y;
`endif

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    x_d     = x_q;
    acc_d   = acc_q;
    bit_d   = bit_q;
    d_d     = d_q;
    y_d     = y_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          r_d     = r_in;
          x_d     = x_in;
          y_d     = '0;
          err_d   = 1'b0;
          state_d = SQUARE;
        end
      end
      SQUARE: begin
        if (x_q > r_q) begin
          err_d   = 1'b1;
          y_d     = '0;
          state_d = DONE;
        end else begin
          d_d     = r_sq - x_sq;
          acc_d   = '0;
          bit_d   = {1'b1, {(WIDTH-1){1'b0}}};
          state_d = ROOT;
        end
      end
      ROOT: begin
        acc_d = step_y;
        bit_d = bit_q >> 1;
        if (bit_q[0]) begin
          y_d     = final_y;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      x_q         <= '0;
      acc_q       <= '0;
      bit_q       <= '0;
      d_q         <= '0;
      y_q         <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      bit_q       <= bit_d;
      d_q         <= d_d;
      y_q         <= y_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y_out     = y_q;
  assign err       = err_q;

endmodule

// File: tb/tb_leg_recover.sv
// Scoreboard bench for leg_recover: directed corner cases then randomized pairs.
module tb_leg_recover;

  localparam int W = 8;

  typedef struct {
    int y;
    int e;
    int lat;
    int acc;
    int hold;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] r_in, x_in;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] y_out;
  logic         err;
  logic         out_valid;
  logic         out_ready;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   rnd_ready = 1'b0;
  exp_t sb[$];

  leg_recover #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .r_in      (r_in),
    .x_in      (x_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_out     (y_out),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: largest y with y*y <= r*r - x*x, optionally rounded to nearest.
  function automatic void model(input int r, input int x, output int y, output int e);
    int d;
    if (x > r) begin
      y = 0;
      e = 1;
      return;
    end
    e = 0;
    d = r * r - x * x;
    y = int'($floor($sqrt(real'(d))));
    while (y * y > d) y--;
    while ((y + 1) * (y + 1) <= d) y++;
`ifdef LEG_RECOVER_ROUND_EN
    if (d - y * y > y && y < (1 << W) - 1) y++;
`endif
  endfunction

  task automatic send(input int r, input int x, input int hold);
    int   n;
    int   y;
    int   e;
    exp_t ex;
    @(posedge clk);
    #1;
    r_in     = W'(r);
    x_in     = W'(x);
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, expected accept", n);
      in_valid = 1'b0;
      return;
    end
    model(r, x, y, e);
    ex.y    = y;
    ex.e    = e;
    ex.lat  = (e != 0) ? 2 : W + 2;
    ex.acc  = cyc + 1;
    ex.hold = hold;
    sb.push_back(ex);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin : monitor
    bit           ov_prev = 1'b0, hold_prev = 1'b0, xfer_prev = 1'b0;
    bit           rst_prev = 1'b0, acc_prev = 1'b0;
    int           hold_cnt = 0;
    logic [W-1:0] y_prev = '0;
    logic         e_prev = 1'b0;
    exp_t         ex;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (rst_prev) begin
          check("rst_in_ready", int'(in_ready), 0);
          check("rst_out_valid", int'(out_valid), 0);
          check("rst_y_out", int'(y_out), 0);
          check("rst_err", int'(err), 0);
        end
        rst_prev = 1'b1; ov_prev = 1'b0; hold_prev = 1'b0;
        xfer_prev = 1'b0; acc_prev = 1'b0; out_ready = 1'b0;
        continue;
      end
      rst_prev = 1'b0;
      if (acc_prev) begin
        check("accept_clears_y", int'(y_out), 0);
        check("accept_clears_err", int'(err), 0);
      end
      acc_prev = in_valid && in_ready;
      if (xfer_prev) begin
        check("idle_after_xfer_in_ready", int'(in_ready), 1);
        check("idle_after_xfer_out_valid", int'(out_valid), 0);
      end
      if (hold_prev) begin
        check("hold_out_valid", int'(out_valid), 1);
        check("hold_y_out", int'(y_out), int'(y_prev));
        check("hold_err", int'(err), int'(e_prev));
      end
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out_valid: got y_out=%0d err=%0d, expected no result", y_out, err);
        end else begin
          hold_cnt = sb[0].hold;
          check("latency", cyc + 1 - sb[0].acc, sb[0].lat);
        end
      end
      if (out_valid) check("in_ready_with_out_valid", int'(in_ready), 0);
      xfer_prev = 1'b0;
      hold_prev = 1'b0;
      if (out_valid) begin
        if (hold_cnt > 0) begin
          out_ready = 1'b0;
          hold_cnt--;
        end else begin
          out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (out_ready) begin
          if (sb.size() != 0) begin
            ex = sb.pop_front();
            check("y_out", int'(y_out), ex.y);
            check("err", int'(err), ex.e);
          end
          xfer_prev = 1'b1;
        end else begin
          hold_prev = 1'b1;
          y_prev    = y_out;
          e_prev    = err;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      ov_prev = out_valid;
    end
  end

  initial begin : stimulus
    int n;
    int r;
    int x;
    rst      = 1'b1;
    in_valid = 1'b0;
    r_in     = '0;
    x_in     = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_reset", int'(in_ready), 1);

    send(5, 3, 0);
    send(255, 0, 0);
    send(10, 10, 0);
    send(5, 7, 0);
    send(3, 1, 0);
    send(10, 6, 5);

    // Abort mid-ROOT: acceptance edge, SQUARE, then reset lands in the 4th ROOT cycle.
    send(200, 100, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_abort", int'(in_ready), 1);
    send(13, 5, 0);

    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 255));
      x = ($urandom_range(0, 7) == 0) ? r : int'($urandom_range(0, 255));
      send(r, x, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    tests++;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/leg_recover.md
LEG_RECOVER -- requirements
Module: leg_recover

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of magnitude, leg and result.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port r_in, input, WIDTH: magnitude (hypotenuse) r, unsigned.
REQ-005 SHALL have port x_in, input, WIDTH: known leg x, unsigned.
REQ-006 SHALL have port in_valid, input, 1: r_in/x_in valid.
REQ-007 SHALL have port in_ready, output, 1: block can accept an operand pair.
REQ-008 SHALL have port y_out, output, WIDTH: recovered leg y.
REQ-009 SHALL have port err, output, 1: x_in exceeded r_in for the current result.
REQ-010 SHALL have port out_valid, output, 1: y_out/err valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the result.

Function
REQ-012 SHALL compute y = floor(sqrt(r*r - x*x)), with 2*WIDTH-bit unsigned intermediates and no overflow.
REQ-013 SHALL implement FSM states IDLE, SQUARE, ROOT, DONE.
REQ-014 SHALL assert in_ready only in IDLE; an operand pair is accepted on an edge with in_valid && in_ready, is registered, and moves the FSM to SQUARE.
REQ-015 SHALL, in SQUARE, register d = r*r - x*x and set the bit index to WIDTH-1, then move to ROOT; if x > r it SHALL instead set err=1 and y=0 and move directly to DONE.
REQ-016 SHALL, in ROOT, resolve one result bit per cycle, MSB first: set the bit when (y | bit)^2 <= d; after bit 0 it SHALL move to DONE.
REQ-017 SHALL, in the normal path, assert out_valid exactly WIDTH+2 cycles after the acceptance edge (10 cycles for WIDTH=8); the err path SHALL assert it 2 cycles after acceptance.
REQ-018 SHALL, in DONE, hold out_valid, y_out and err stable until an edge with out_ready=1, then return to IDLE.
REQ-019 SHALL NOT assert in_ready in the same cycle as out_valid; back-to-back throughput is one result per WIDTH+3 cycles.
REQ-020 SHALL ignore in_valid while not in IDLE, and SHALL ignore out_ready while not in DONE.
REQ-021 SHALL keep y_out and err at their last values outside DONE, and SHALL clear them on the acceptance edge of a new pair.
REQ-022 SHALL produce y=0, err=0 when x equals r.

Reset
REQ-023 SHALL, while rst=1, force the FSM to IDLE; y_out=0, err=0, out_valid=0, in_ready=0.
REQ-024 SHALL assert in_ready=1 in the first cycle after rst is released.
REQ-025 SHALL abandon any in-flight computation when rst is asserted in any state, with no partial result emitted.

Configuration
REQ-026 SHALL use macro LEG_RECOVER_ROUND_EN to select rounding.
REQ-027 SHALL, with LEG_RECOVER_ROUND_EN defined, round y to nearest: increment y when d - y^2 > y, saturating at 2^WIDTH-1, decided in the final ROOT cycle with latency unchanged.
REQ-028 SHALL, without LEG_RECOVER_ROUND_EN, output the truncated (floor) root.

Structure
REQ-029 SHALL place the FSM state enum and default WIDTH constant in shared package leg_recover_pkg.
REQ-030 SHALL implement the per-bit trial-square compare as sub-module isqrt_step, with inputs y, bit and d, and outputs y_next.

Verification
REQ-031 Bench SHALL drive r=5, x=3 -> y_out=4, err=0, out_valid exactly 10 cycles after acceptance.
REQ-032 Bench SHALL drive r=255, x=0 -> y_out=255, and r=10, x=10 -> y_out=0, err=0.
REQ-033 Bench SHALL drive r=5, x=7 -> err=1, y_out=0, out_valid 2 cycles after acceptance.
REQ-034 Bench SHALL drive r=3, x=1 (d=8) -> y_out=2 without LEG_RECOVER_ROUND_EN, y_out=3 with it.
REQ-035 Bench SHALL drive r=10, x=6 with out_ready held low 5 cycles -> y_out=8 held stable, in_ready=0 throughout; IDLE reached the cycle after out_ready=1.
REQ-036 Bench SHALL assert rst in the 4th ROOT cycle -> out_valid never asserts; the next pair r=13, x=5 -> y_out=12.
